branch_pc_unit: RTL and testbench



---
 rtl/branch_pc_unit_if.sv | 30 +++
 rtl/branch_pc_unit.sv | 116 +++++++++++
 tb/tb_branch_pc_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/branch_pc_unit_if.sv
// rtl/branch_pc_unit_if.sv - decode-side request and fetch-side status bundle for branch_pc_unit
interface branch_pc_unit_if #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic          valid;
  logic          stall;
  logic [4:0]    opcode;
  logic [DW-1:0] cond;
  logic [AW-1:0] imm_tgt;
  logic [AW-1:0] reg_tgt;
  logic [AW-1:0] pc;
  logic          taken;
  logic          flush;
  logic          ras_err;
  logic [CW-1:0] ras_cnt;

  modport master (
    output valid, stall, opcode, cond, imm_tgt, reg_tgt,
    input  pc, taken, flush, ras_err, ras_cnt
  );

  modport slave (
    input  valid, stall, opcode, cond, imm_tgt, reg_tgt,
    output pc, taken, flush, ras_err, ras_cnt
  );
endinterface

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - registered fetch PC with branch resolution and a return-address stack
module branch_pc_unit #(
  parameter int            AW        = 8,
  parameter int            DW        = 8,
  parameter int            RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC  = '0
) (
  input logic             clk,
  input logic             rst,
  branch_pc_unit_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [4:0] OP_BNE  = 5'b10011;
  localparam logic [4:0] OP_BE   = 5'b10100;
  localparam logic [4:0] OP_BNER = 5'b10101;
  localparam logic [4:0] OP_BER  = 5'b10110;
  localparam logic [4:0] OP_J    = 5'b10111;
  localparam logic [4:0] OP_JR   = 5'b11000;
  localparam logic [4:0] OP_CALL = 5'b11001;
  localparam logic [4:0] OP_RET  = 5'b11010;

  logic [AW-1:0] pc_q;
  logic          taken_q;
  logic          flush_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] ras_mem [0:(1<<IW)-1];

  logic [DW-1:0] cond_v;
  logic          cond_nz;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] target;
  logic [AW-1:0] ras_top;
  logic          ras_full;
  logic          ras_empty;
  logic          redirect;
  logic          push;
  logic          pop;
  logic          err_set;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;

  assign cond_v    = bus.cond;
  assign cond_nz   = |cond_v;
  assign pc_inc    = pc_q + AW'(1);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_empty = (cnt_q == '0);
  assign push_idx  = IW'(cnt_q);
  assign top_idx   = IW'(cnt_q - CW'(1));
  assign ras_top   = ras_mem[top_idx];

  always_comb begin
    redirect = 1'b0;
    target   = pc_inc;
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    if (bus.valid) begin
      case (bus.opcode)
        OP_BNE:  begin redirect = cond_nz;  target = bus.imm_tgt; end
        OP_BE:   begin redirect = !cond_nz; target = bus.imm_tgt; end
        OP_BNER: begin redirect = cond_nz;  target = bus.reg_tgt; end
        OP_BER:  begin redirect = !cond_nz; target = bus.reg_tgt; end
        OP_J:    begin redirect = 1'b1;     target = bus.imm_tgt; end
        OP_JR:   begin redirect = 1'b1;     target = bus.reg_tgt; end
        OP_CALL: begin
          // A full stack still takes the jump; only the return address is lost.
          redirect = 1'b1;
          target   = bus.imm_tgt;
          push     = !ras_full;
          err_set  = ras_full;
        end
        OP_RET: begin
          redirect = !ras_empty;
          pop      = !ras_empty;
          err_set  = ras_empty;
          target   = ras_top;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.stall) begin
      taken_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= redirect ? target : pc_inc;
      taken_q <= redirect;
      flush_q <= redirect;
      if (err_set) err_q <= 1'b1;
      if (push)     cnt_q <= cnt_q + CW'(1);
      else if (pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Stack contents need no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (!rst && !bus.stall && push) ras_mem[push_idx] <= pc_inc;
  end

  assign bus.pc      = pc_q;
  assign bus.taken   = taken_q;
  assign bus.flush   = flush_q;
  assign bus.ras_err = err_q;
  assign bus.ras_cnt = cnt_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit with directed vectors
module tb_branch_pc_unit;
  localparam logic [4:0] BNE  = 5'b10011;
  localparam logic [4:0] BE   = 5'b10100;
  localparam logic [4:0] BNER = 5'b10101;
  localparam logic [4:0] BER  = 5'b10110;
  localparam logic [4:0] J    = 5'b10111;
  localparam logic [4:0] JR   = 5'b11000;
  localparam logic [4:0] CALL = 5'b11001;
  localparam logic [4:0] RET  = 5'b11010;
  localparam logic [4:0] NOP  = 5'b00001;

  typedef struct {
    logic [7:0] pc;
    logic       tk;
    logic       err;
    logic [2:0] cnt;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];

  branch_pc_unit_if #(.AW(8), .DW(8), .RAS_DEPTH(4)) bus ();

  branch_pc_unit #(.AW(8), .DW(8), .RAS_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, exp);
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [4:0] op,
                      input logic [7:0] c, input logic [7:0] it, input logic [7:0] rt,
                      input logic [7:0] epc, input logic etk, input logic eerr,
                      input logic [2:0] ecnt, input string nm);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.valid   = v;
    bus.stall   = s;
    bus.opcode  = op;
    bus.cond    = c;
    bus.imm_tgt = it;
    bus.reg_tgt = rt;
    e.pc = epc; e.tk = etk; e.err = eerr; e.cnt = ecnt; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "pc",      bus.pc,               e.pc);
        chk(e.name, "taken",   {7'd0, bus.taken},    {7'd0, e.tk});
        chk(e.name, "flush",   {7'd0, bus.flush},    {7'd0, e.tk});
        chk(e.name, "ras_err", {7'd0, bus.ras_err},  {7'd0, e.err});
        chk(e.name, "ras_cnt", {5'd0, bus.ras_cnt},  {5'd0, e.cnt});
      end
    end
  end

  initial begin
    bus.valid = 1'b0; bus.stall = 1'b0; bus.opcode = NOP;
    bus.cond = 8'h00; bus.imm_tgt = 8'h00; bus.reg_tgt = 8'h00;

    // reset then sequential run
    step(1, 0, 0, NOP, 0, 0, 0, 8'h00, 0, 0, 0, "rst0");
    step(1, 0, 0, NOP, 0, 0, 0, 8'h00, 0, 0, 0, "rst1");
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, NOP, 0, 0, 0, 8'(i), 0, 0, 0, "seq");

    // wrap at the top of the address space
    step(0, 1, 0, J,   0, 8'hFE, 0, 8'hFE, 1, 0, 0, "j_fe");
    step(0, 0, 0, NOP, 0, 0,     0, 8'hFF, 0, 0, 0, "seq_ff");
    step(0, 0, 0, NOP, 0, 0,     0, 8'h00, 0, 0, 0, "wrap");

    // conditional branches; BNE issued during the J flush cycle
    step(0, 1, 0, J,    0,     8'h10, 0,     8'h10, 1, 0, 0, "j_10");
    step(0, 1, 0, BNE,  8'h03, 8'h40, 0,     8'h40, 1, 0, 0, "bne_tk");
    step(0, 0, 0, NOP,  0,     0,     0,     8'h41, 0, 0, 0, "post_bne");
    step(0, 1, 0, BNE,  8'h00, 8'h99, 0,     8'h42, 0, 0, 0, "bne_nt");
    step(0, 1, 0, BE,   8'h00, 8'h20, 0,     8'h20, 1, 0, 0, "be_tk");
    step(0, 1, 0, BE,   8'h80, 8'h70, 0,     8'h21, 0, 0, 0, "be_nt");
    step(0, 1, 0, BER,  8'h00, 8'h11, 8'h33, 8'h33, 1, 0, 0, "ber_tk");
    step(0, 1, 0, BNER, 8'h01, 8'h11, 8'h55, 8'h55, 1, 0, 0, "bner_tk");
    step(0, 1, 0, BNER, 8'h00, 8'h11, 8'h66, 8'h56, 0, 0, 0, "bner_nt");
    step(0, 1, 0, JR,   0,     8'h11, 8'h7A, 8'h7A, 1, 0, 0, "jr");
    step(0, 1, 0, NOP,  8'h01, 8'h11, 8'h22, 8'h7B, 0, 0, 0, "other_op");

    // stall beats a presented jump
    step(0, 1, 0, J, 0, 8'h05, 0, 8'h05, 1, 0, 0, "j_05");
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, J, 0, 8'h50, 0, 8'h05, 0, 0, 0, "stall_hold");
    step(0, 1, 0, J, 0, 8'h50, 0, 8'h50, 1, 0, 0, "stall_rel");

    // nested CALL/RET, plus a stalled CALL that must not push
    step(0, 1, 0, J,    0, 8'h02, 0, 8'h02, 1, 0, 0, "j_02");
    step(0, 1, 0, CALL, 0, 8'h30, 0, 8'h30, 1, 0, 1, "call_30");
    step(0, 1, 0, CALL, 0, 8'h60, 0, 8'h60, 1, 0, 2, "call_60");
    step(0, 1, 0, RET,  0, 0,     0, 8'h31, 1, 0, 1, "ret_31");
    step(0, 1, 0, RET,  0, 0,     0, 8'h03, 1, 0, 0, "ret_03");
    step(0, 1, 1, CALL, 0, 8'h77, 0, 8'h03, 0, 0, 0, "stall_call");

    // overflow then underflow at depth 4
    step(0, 1, 0, CALL, 0, 8'h80, 0, 8'h80, 1, 0, 1, "call1");
    step(0, 1, 0, CALL, 0, 8'h90, 0, 8'h90, 1, 0, 2, "call2");
    step(0, 1, 0, CALL, 0, 8'hA0, 0, 8'hA0, 1, 0, 3, "call3");
    step(0, 1, 0, CALL, 0, 8'hB0, 0, 8'hB0, 1, 0, 4, "call4");
    step(0, 1, 0, CALL, 0, 8'hC0, 0, 8'hC0, 1, 1, 4, "call5_ovf");
    step(0, 1, 0, RET,  0, 0,     0, 8'hA1, 1, 1, 3, "ret1");
    step(0, 1, 0, RET,  0, 0,     0, 8'h91, 1, 1, 2, "ret2");
    step(0, 1, 0, RET,  0, 0,     0, 8'h81, 1, 1, 1, "ret3");
    step(0, 1, 0, RET,  0, 0,     0, 8'h04, 1, 1, 0, "ret4");
    step(0, 1, 0, RET,  0, 0,     0, 8'h05, 0, 1, 0, "ret5_unf");
    step(1, 0, 0, NOP,  0, 0,     0, 8'h00, 0, 0, 0, "rst_clr");

    // reset aborts a concurrent CALL
    step(0, 1, 0, J,    0, 8'h20, 0, 8'h20, 1, 0, 0, "j_20");
    step(1, 1, 0, CALL, 0, 8'h44, 0, 8'h00, 0, 0, 0, "rst_call");
    step(0, 0, 0, NOP,  0, 0,     0, 8'h01, 0, 0, 0, "after_rst");

    // return address wraps when calling from 0xFF
    step(0, 1, 0, J,    0, 8'hFF, 0, 8'hFF, 1, 0, 0, "j_ff");
    step(0, 1, 0, CALL, 0, 8'h10, 0, 8'h10, 1, 0, 1, "call_wrap");
    step(0, 1, 0, RET,  0, 0,     0, 8'h00, 1, 0, 0, "ret_wrap");

    @(negedge clk);
    bus.valid = 1'b0;
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
